// File: rtl/dmi_reg_host.sv
// Register-mapped DMI initiator: a CTRL write launches one DMI request, and the block runs the
// request/response handshakes and captures the result into RDATA/STATUS.
module dmi_reg_host #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmi_rst_ni,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [1:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_rvalid_o,
  output logic [40:0] dmi_req_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  logic [33:0] dmi_resp_i,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_WDATA  = 2'd1;
  localparam logic [1:0] ADDR_RDATA  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] RESP_ERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic [31:0]     wdata_q;
  logic [31:0]     dmi_rdata_q;
  logic [6:0]      last_addr_q;
  logic [1:0]      last_op_q;
  logic [1:0]      resp_q;
  logic            overrun_q;
  logic            timeout_q;
  logic [40:0]     req_q;
  logic [31:0]     reg_rdata_q;
  logic            reg_rvalid_q;

  logic        busy;
  logic        reg_wr;
  logic        ctrl_wr;
  logic        wdata_wr;
  logic        status_wr;
  logic        op_legal;
  logic        launch;
  logic        resp_fire;
  logic        timeout_hit;
  logic [31:0] rd_mux;

  assign busy      = (state_q != IDLE);
  assign reg_wr    = reg_req_i & reg_we_i;
  assign ctrl_wr   = reg_wr & (reg_addr_i == ADDR_CTRL);
  assign wdata_wr  = reg_wr & (reg_addr_i == ADDR_WDATA);
  assign status_wr = reg_wr & (reg_addr_i == ADDR_STATUS);
  assign op_legal  = (reg_wdata_i[1:0] == OP_READ) | (reg_wdata_i[1:0] == OP_WRITE);

  // A CTRL write that lands in the completion cycle still sees busy and counts as overrun.
  assign launch      = ctrl_wr & ~busy & op_legal & dmi_rst_ni;
  assign resp_fire   = (state_q == RSP) & dmi_resp_valid_i & dmi_rst_ni;
  assign timeout_hit = (state_q == RSP) & ~dmi_resp_valid_i & dmi_rst_ni
                     & (cnt_q == CntW'(TimeoutCycles - 1));

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = REQ;
      REQ:     if (dmi_req_ready_i) state_d = RSP;
      RSP:     if (dmi_resp_valid_i || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!dmi_rst_ni) state_d = IDLE;
  end

  always_comb begin
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    case (state_q)
      REQ:     dmi_req_valid_o  = 1'b1;
      RSP:     dmi_resp_ready_o = 1'b1;
      default: ;
    endcase
  end

  // Runs only while waiting for a response; the exit at TimeoutCycles-1 keeps it from wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i)                cnt_q <= '0;
    else if (state_q == RSP)  cnt_q <= cnt_q + 1'b1;
    else                      cnt_q <= '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdata_q     <= '0;
      dmi_rdata_q <= '0;
      last_addr_q <= '0;
      last_op_q   <= '0;
      resp_q      <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      req_q       <= '0;
    end else begin
      if (launch) begin
        req_q       <= {reg_wdata_i[14:8], wdata_q, reg_wdata_i[1:0]};
        last_addr_q <= reg_wdata_i[14:8];
        last_op_q   <= reg_wdata_i[1:0];
      end
      if (wdata_wr && !busy) wdata_q <= reg_wdata_i;

      if (!dmi_rst_ni) begin
        if (busy) resp_q <= RESP_ERR;
      end else if (resp_fire) begin
        dmi_rdata_q <= dmi_resp_i[33:2];
        resp_q      <= dmi_resp_i[1:0];
      end else if (timeout_hit) begin
        resp_q <= RESP_ERR;
      end

      // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
      overrun_q <= (overrun_q & ~(status_wr & reg_wdata_i[3])) | (ctrl_wr & busy);
      timeout_q <= (timeout_q & ~(status_wr & reg_wdata_i[4])) | timeout_hit;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (reg_addr_i)
      ADDR_CTRL:   rd_mux = {17'd0, last_addr_q, 6'd0, last_op_q};
      ADDR_WDATA:  rd_mux = wdata_q;
      ADDR_RDATA:  rd_mux = dmi_rdata_q;
      ADDR_STATUS: rd_mux = {27'd0, timeout_q, overrun_q, resp_q, busy};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_rvalid_q <= 1'b0;
      reg_rdata_q  <= '0;
    end else begin
      reg_rvalid_q <= reg_req_i & ~reg_we_i;
      reg_rdata_q  <= (reg_req_i && !reg_we_i) ? rd_mux : '0;
    end
  end

  assign reg_rdata_o  = reg_rdata_q;
  assign reg_rvalid_o = reg_rvalid_q;
  assign dmi_req_o    = req_q;

endmodule

// File: tb/tb_dmi_reg_host.sv
// Bench for dmi_reg_host: a transaction-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_dmi_reg_host;

  localparam int TO = 16;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_WDATA  = 2'd1;
  localparam logic [1:0] A_RDATA  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dmi_rst_ni;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_rvalid_o;
  logic [40:0] dmi_req_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [33:0] dmi_resp_i;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;

  int n_checks = 0;
  int n_errors = 0;

  dmi_reg_host #(.TimeoutCycles(TO)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dmi_rst_ni       (dmi_rst_ni),
    .reg_req_i        (reg_req_i),
    .reg_we_i         (reg_we_i),
    .reg_addr_i       (reg_addr_i),
    .reg_wdata_i      (reg_wdata_i),
    .reg_rdata_o      (reg_rdata_o),
    .reg_rvalid_o     (reg_rvalid_o),
    .dmi_req_o        (dmi_req_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 no transaction, 1 awaiting accept, 2 awaiting response.
  typedef struct packed {
    logic [1:0]  phase;
    logic [31:0] rsp_cycles;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [1:0]  resp;
    logic        overrun;
    logic        timeout;
    logic [40:0] req;
    logic        rvalid;
    logic [31:0] rdout;
  } model_t;

  function automatic model_t model_step(input model_t s);
    model_t n = s;
    logic busy = (s.phase != 2'd0);
    logic to_set = 1'b0;
    logic [1:0] op = reg_wdata_i[1:0];
    if (rst_i) return '0;

    n.rvalid = reg_req_i && !reg_we_i;
    n.rdout  = 32'd0;
    if (n.rvalid) begin
      case (reg_addr_i)
        A_CTRL:   n.rdout = 32'(s.addr) * 256 + 32'(s.op);
        A_WDATA:  n.rdout = s.wdata;
        A_RDATA:  n.rdout = s.rdata;
        default:  n.rdout = 32'(busy) + 32'(s.resp) * 2 + 32'(s.overrun) * 8 + 32'(s.timeout) * 16;
      endcase
    end

    if (!dmi_rst_ni) begin
      if (busy) n.resp = 2'b11;
      n.phase = 2'd0;
    end else if (s.phase == 2'd1) begin
      if (dmi_req_ready_i) begin
        n.phase = 2'd2;
        n.rsp_cycles = 0;
      end
    end else if (s.phase == 2'd2) begin
      if (dmi_resp_valid_i) begin
        n.rdata = dmi_resp_i[33:2];
        n.resp  = dmi_resp_i[1:0];
        n.phase = 2'd0;
      end else begin
        n.rsp_cycles = s.rsp_cycles + 1;
        if (n.rsp_cycles == TO) begin
          n.phase = 2'd0;
          n.timeout = 1'b1;
          n.resp = 2'b11;
          to_set = 1'b1;
        end
      end
    end

    if (reg_req_i && reg_we_i) begin
      case (reg_addr_i)
        A_CTRL: begin
          if (busy) n.overrun = 1'b1;
          else if (dmi_rst_ni && (op == 2'd1 || op == 2'd2)) begin
            n.addr  = reg_wdata_i[14:8];
            n.op    = op;
            n.req   = {reg_wdata_i[14:8], s.wdata, op};
            n.phase = 2'd1;
          end
        end
        A_WDATA:  if (!busy) n.wdata = reg_wdata_i;
        A_STATUS: begin
          if (reg_wdata_i[3]) n.overrun = 1'b0;
          if (reg_wdata_i[4] && !to_set) n.timeout = 1'b0;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  model_t m;
  logic started = 1'b0;

  always @(posedge clk_i) begin
    m <= model_step(m);
    started <= 1'b1;
  end

  always @(negedge clk_i) begin
    if (started === 1'b1) begin
      check("dmi_req_valid",  {63'd0, dmi_req_valid_o},  {63'd0, m.phase == 2'd1});
      check("dmi_resp_ready", {63'd0, dmi_resp_ready_o}, {63'd0, m.phase == 2'd2});
      check("dmi_req",        {23'd0, dmi_req_o},        {23'd0, m.req});
      check("reg_rvalid",     {63'd0, reg_rvalid_o},     {63'd0, m.rvalid});
      check("reg_rdata",      {32'd0, reg_rdata_o},      {32'd0, m.rdout});
    end
  end

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    @(negedge clk_i);
    reg_req_i = 1'b0; reg_we_i = 1'b0; reg_wdata_i = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a;
    @(negedge clk_i);
    d = reg_rdata_o;
    reg_req_i = 1'b0;
  endtask

  task automatic accept_req();
    dmi_req_ready_i = 1'b1;
    @(negedge clk_i);
    dmi_req_ready_i = 1'b0;
  endtask

  task automatic give_resp(input logic [31:0] data, input logic [1:0] resp);
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {data, resp};
    @(negedge clk_i);
    dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    rst_i = 1'b1; dmi_rst_ni = 1'b1;
    reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    dmi_req_ready_i = 1'b0; dmi_resp_i = '0; dmi_resp_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_req",   {23'd0, dmi_req_o}, 64'd0);
    check("reset_valid", {63'd0, dmi_req_valid_o}, 64'd0);
    rst_i = 1'b0;

    // 1: write 0xDEADBEEF to DMI addr 0x10, ready after 3 cycles
    reg_write(A_WDATA, 32'hDEADBEEF);
    reg_write(A_CTRL, 32'h0000_1002);
    for (int i = 0; i < 3; i++) begin
      check("t1_payload", {23'd0, dmi_req_o}, {23'd0, 7'h10, 32'hDEADBEEF, 2'b10});
      check("t1_valid", {63'd0, dmi_req_valid_o}, 64'd1);
      @(negedge clk_i);
    end
    accept_req();
    give_resp(32'h0BADF00D, 2'b00);
    reg_read(A_STATUS, d); check("t1_status", {32'd0, d}, 64'h0);
    reg_read(A_CTRL, d);   check("t1_ctrl",   {32'd0, d}, 64'h1002);

    // 2: read DMI addr 0x11
    reg_write(A_CTRL, 32'h0000_1101);
    check("t2_payload", {23'd0, dmi_req_o}, {23'd0, 7'h11, 32'hDEADBEEF, 2'b01});
    dmi_req_ready_i = 1'b1;
    reg_read(A_STATUS, d); check("t2_busy", {32'd0, d}, 64'h1);
    dmi_req_ready_i = 1'b0;
    give_resp(32'h12345678, 2'b00);
    reg_read(A_STATUS, d); check("t2_idle",  {32'd0, d}, 64'h0);
    reg_read(A_RDATA, d);  check("t2_rdata", {32'd0, d}, 64'h12345678);

    // 3: response never arrives -> timeout after TO response cycles
    reg_write(A_CTRL, 32'h0000_2201);
    accept_req();
    repeat (TO - 1) @(negedge clk_i);
    check("t3_still_waiting", {63'd0, dmi_resp_ready_o}, 64'd1);
    @(negedge clk_i);
    check("t3_abandoned", {63'd0, dmi_resp_ready_o}, 64'd0);
    reg_read(A_STATUS, d); check("t3_status",  {32'd0, d}, 64'h16);
    reg_write(A_STATUS, 32'h10);
    reg_read(A_STATUS, d); check("t3_cleared", {32'd0, d}, 64'h06);
    reg_read(A_RDATA, d);  check("t3_rdata_kept", {32'd0, d}, 64'h12345678);

    // 3b: response in the very cycle the timeout would expire wins
    reg_write(A_CTRL, 32'h0000_2301);
    accept_req();
    repeat (TO - 1) @(negedge clk_i);
    give_resp(32'hA5A5A5A5, 2'b01);
    reg_read(A_STATUS, d); check("t3b_status", {32'd0, d}, 64'h02);
    reg_read(A_RDATA, d);  check("t3b_rdata",  {32'd0, d}, 64'hA5A5A5A5);

    // 4: CTRL and WDATA writes while busy are ignored; overrun flagged
    reg_write(A_CTRL, 32'h0000_3302);
    reg_write(A_CTRL, 32'h0000_4401);
    reg_write(A_WDATA, 32'h11111111);
    check("t4_payload", {23'd0, dmi_req_o}, {23'd0, 7'h33, 32'hDEADBEEF, 2'b10});
    reg_read(A_STATUS, d); check("t4_status_busy", {32'd0, d}, 64'h0B);
    accept_req();
    dmi_resp_valid_i = 1'b1; dmi_resp_i = {32'h55AA55AA, 2'b00};
    reg_write(A_CTRL, 32'h0000_4401);
    dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
    check("t4_no_launch", {63'd0, dmi_req_valid_o}, 64'd0);
    reg_read(A_WDATA, d);  check("t4_wdata_kept", {32'd0, d}, 64'hDEADBEEF);
    reg_read(A_STATUS, d); check("t4_overrun", {32'd0, d}, 64'h08);
    reg_write(A_STATUS, 32'h08);
    reg_read(A_STATUS, d); check("t4_w1c", {32'd0, d}, 64'h00);

    // 5: DMI reset during response wait
    reg_write(A_CTRL, 32'h0000_5501);
    accept_req();
    repeat (2) @(negedge clk_i);
    dmi_rst_ni = 1'b0;
    @(negedge clk_i);
    check("t5_valid_drop", {63'd0, dmi_req_valid_o}, 64'd0);
    check("t5_ready_drop", {63'd0, dmi_resp_ready_o}, 64'd0);
    dmi_rst_ni = 1'b1;
    reg_read(A_STATUS, d); check("t5_status", {32'd0, d}, 64'h06);
    reg_write(A_CTRL, 32'h0000_6602);
    check("t5_relaunch", {63'd0, dmi_req_valid_o}, 64'd1);
    check("t5_payload", {23'd0, dmi_req_o}, {23'd0, 7'h66, 32'hDEADBEEF, 2'b10});
    accept_req();
    give_resp(32'hFEEDFACE, 2'b00);
    reg_read(A_RDATA, d); check("t5_rdata", {32'd0, d}, 64'hFEEDFACE);

    // 6: synchronous reset mid-request
    reg_write(A_CTRL, 32'h0000_7701);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t6_req",    {23'd0, dmi_req_o}, 64'd0);
    check("t6_valid",  {63'd0, dmi_req_valid_o}, 64'd0);
    check("t6_ready",  {63'd0, dmi_resp_ready_o}, 64'd0);
    check("t6_rvalid", {63'd0, reg_rvalid_o}, 64'd0);
    rst_i = 1'b0;
    reg_read(A_STATUS, d); check("t6_status", {32'd0, d}, 64'h0);
    reg_read(A_RDATA, d);  check("t6_rdata",  {32'd0, d}, 64'h0);
    reg_read(A_WDATA, d);  check("t6_wdata",  {32'd0, d}, 64'h0);
    reg_read(A_CTRL, d);   check("t6_ctrl",   {32'd0, d}, 64'h0);
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
